// File: rtl/audio_sample_buffer.sv
// audio_sample_buffer: circular sample buffer between the mic/I2S front end
// and the level-meter consumers. Samples are written on a strobe with no
// backpressure. They are stored in an inferred BRAM and streamed out in order
// over a valid/ready port. The path is a 1-cycle synchronous read stage
// followed by a registered output stage. A hysteretic flag announces that a
// burst of samples is available.
module audio_sample_buffer #(
  parameter int DEPTH           = 256,
  parameter int READY_THRESHOLD = 128
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic signed [23:0]       wr_data_i,
  input  logic                     wr_valid_i,
  output logic signed [23:0]       ram_read_data_o,
  output logic                     ram_read_valid_o,
  input  logic                     ram_read_ready_i,
  output logic                     ram_buffer_ready_o,
  output logic [$clog2(DEPTH):0]   fill_level_o,
  output logic                     overflow_o,
  input  logic                     overflow_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] DEPTH_F  = FW'(DEPTH);
  localparam logic [FW-1:0] THRESH_F = FW'(READY_THRESHOLD);
  localparam logic [FW-1:0] ONE_F    = FW'(1);
  localparam logic [AW-1:0] ONE_A    = AW'(1);

  typedef enum logic {
    ST_IDLE,
    ST_AVAIL
  } state_t;

  // Storage and read stage
  logic signed [23:0] r_mem [DEPTH];
  logic signed [23:0] r_bram_q;   // synchronous BRAM read data
  logic               r_pend;     // r_bram_q holds a sample not yet in the output register

  // Bookkeeping
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [FW-1:0] r_mem_cnt;       // committed entries not yet issued to the read stage
  logic [FW-1:0] r_fill;          // every sample held: memory + read stage + output register

  // Output stage and status
  logic signed [23:0] r_data;
  logic               r_valid;
  logic               r_ovf;
  logic               r_buf_rdy;
  state_t             r_state;

  logic w_xfer;
  logic w_out_free;
  logic w_move;
  logic w_issue;
  logic w_drop;
  logic w_accept;

  // Output register is free when empty or handing its sample over this edge.
  assign w_xfer     = r_valid & ram_read_ready_i;
  assign w_out_free = ~r_valid | w_xfer;
  assign w_move     = r_pend & w_out_free;
  // Read a committed entry whenever the read stage is empty or is emptying now,
  // so a streaming consumer sees one sample per cycle with no bubbles.
  assign w_issue    = (r_mem_cnt != '0) & (~r_pend | w_move);
  // Fullness is judged on the registered fill level, even if a read transfers this cycle.
  assign w_drop     = wr_valid_i & (r_fill == DEPTH_F);
  assign w_accept   = wr_valid_i & ~w_drop;

  // BRAM write port and synchronous read port.
  // NOTE: the sample memory and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= wr_data_i;
    end
    if (w_issue) begin
      r_bram_q <= r_mem[r_rd_ptr];
    end
  end

  // Pointers, committed-entry count and total fill level.
  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_mem_cnt <= '0;
      r_fill    <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + ONE_A;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + ONE_A;
      end
      unique case ({w_accept, w_issue})
        2'b10:   r_mem_cnt <= r_mem_cnt + ONE_F;
        2'b01:   r_mem_cnt <= r_mem_cnt - ONE_F;
        default: r_mem_cnt <= r_mem_cnt;
      endcase
      unique case ({w_accept, w_xfer})
        2'b10:   r_fill <= r_fill + ONE_F;
        2'b01:   r_fill <= r_fill - ONE_F;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Read-stage occupancy and the registered output stage.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_pend <= w_issue | (r_pend & ~w_move);
      if (w_move) begin
        r_data  <= r_bram_q;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (overflow_clr_i) begin
      r_ovf <= 1'b0;
    end
  end

  // Burst-available FSM evaluated on the registered fill level; flag lags fill by one cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_buf_rdy <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (r_fill >= THRESH_F) begin
            r_state   <= ST_AVAIL;
            r_buf_rdy <= 1'b1;
          end
        end
        ST_AVAIL: begin
          if (r_fill == '0) begin
            r_state   <= ST_IDLE;
            r_buf_rdy <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_buf_rdy <= 1'b0;
        end
      endcase
    end
  end

  assign ram_read_data_o    = r_data;
  assign ram_read_valid_o   = r_valid;
  assign ram_buffer_ready_o = r_buf_rdy;
  assign fill_level_o       = r_fill;
  assign overflow_o         = r_ovf;

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Testbench for audio_sample_buffer (DEPTH=8, READY_THRESHOLD=4).
// A queue-based model predicts every output each cycle. Directed sequences
// add literal expectations at the points of interest.
module tb_audio_sample_buffer;

  localparam int DEPTH  = 8;
  localparam int THRESH = 4;
  localparam int FW     = $clog2(DEPTH) + 1;
  localparam logic [23:0] RAMP0 = 24'h7FFE00;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [23:0]   wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          rd_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [23:0]   rd_data;
  logic          rd_valid;
  logic          buf_ready;
  logic [FW-1:0] fill;
  logic          ovf;

  always #5 clk = ~clk;

  audio_sample_buffer #(.DEPTH(DEPTH), .READY_THRESHOLD(THRESH)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .wr_data_i          (wr_data),
    .wr_valid_i         (wr_valid),
    .ram_read_data_o    (rd_data),
    .ram_read_valid_o   (rd_valid),
    .ram_read_ready_i   (rd_ready),
    .ram_buffer_ready_o (buf_ready),
    .fill_level_o       (fill),
    .overflow_o         (ovf),
    .overflow_clr_i     (ovf_clr)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Every held sample sits in q; the head is shown once it is two edges old
  // and the output is free. Fill is simply the queue length.
  typedef struct {
    logic [23:0] d;
    int          rdy_at;
  } ent_t;

  ent_t        q[$];
  int          e = 0;
  logic        model_live = 1'b0;
  logic        m_valid = 1'b0;
  logic [23:0] m_data = '0;
  logic        m_ovf = 1'b0;
  logic        m_flag = 1'b0;

  always @(posedge clk) begin
    int  fill_before;
    logic xfer;
    logic drop;
    e++;
    if (!rst_n) begin
      q.delete();
      m_valid    = 1'b0;
      m_data     = '0;
      m_ovf      = 1'b0;
      m_flag     = 1'b0;
      model_live = 1'b1;
    end else begin
      fill_before = q.size();
      xfer = m_valid && rd_ready;
      drop = wr_valid && (fill_before == DEPTH);
      if (!m_flag && fill_before >= THRESH) m_flag = 1'b1;
      else if (m_flag && fill_before == 0) m_flag = 1'b0;
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (xfer) begin
        q.delete(0);
        m_valid = 1'b0;
      end
      if (wr_valid && !drop) q.push_back('{d: wr_data, rdy_at: e + 2});
      if (!m_valid && q.size() > 0 && q[0].rdy_at <= e) begin
        m_valid = 1'b1;
        m_data  = q[0].d;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        prev_hold = 1'b0;
  logic [23:0] prev_data = '0;
  logic        cap_en = 1'b0;
  logic [23:0] rx[$];

  always @(negedge clk) begin
    if (model_live) begin
      check("valid", 32'(rd_valid), 32'(m_valid));
      if (m_valid) check("data", 32'(rd_data), 32'(m_data));
      check("fill", 32'(fill), 32'(q.size()));
      check("overflow", 32'(ovf), 32'(m_ovf));
      check("buffer_ready", 32'(buf_ready), 32'(m_flag));
      if (prev_hold) begin
        check("hold_valid", 32'(rd_valid), 32'(1));
        check("hold_data", 32'(rd_data), 32'(prev_data));
      end
      prev_hold = rst_n && rd_valid && !rd_ready;
      prev_data = rd_data;
      if (cap_en && rd_valid && rd_ready) rx.push_back(rd_data);
    end
  end

  // Apply one cycle of inputs, let the edge consume them, return just after it.
  task automatic cyc(input logic wv, input logic [23:0] wd, input logic rr, input logic clr);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    ovf_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int sent;
    int drain;

    // 1. reset then idle
    rst_n = 1'b0;
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc(0, '0, 0, 0);
    check("t1_valid", 32'(rd_valid), 32'(0));
    check("t1_data", 32'(rd_data), 32'(0));
    check("t1_fill", 32'(fill), 32'(0));
    check("t1_ovf", 32'(ovf), 32'(0));
    check("t1_bufrdy", 32'(buf_ready), 32'(0));

    // 2. single sample latency
    cyc(1, 24'h800001, 1, 0);
    check("t2_fill_after_wr", 32'(fill), 32'(1));
    check("t2_valid_n1", 32'(rd_valid), 32'(0));
    cyc(0, '0, 1, 0);
    check("t2_valid_n1b", 32'(rd_valid), 32'(0));
    cyc(0, '0, 1, 0);
    check("t2_valid_n2", 32'(rd_valid), 32'(1));
    check("t2_data_n2", 32'(rd_data), 32'h800001);
    cyc(0, '0, 1, 0);
    check("t2_valid_after", 32'(rd_valid), 32'(0));
    check("t2_fill_after", 32'(fill), 32'(0));

    // 3. threshold hysteresis
    for (int i = 0; i < 4; i++) cyc(1, 24'h10 + 24'(i), 0, 0);
    check("t3_fill4", 32'(fill), 32'(4));
    check("t3_flag_lag", 32'(buf_ready), 32'(0));
    cyc(0, '0, 0, 0);
    check("t3_flag_up", 32'(buf_ready), 32'(1));
    for (int i = 0; i < 3; i++) begin
      check("t3_rd_valid", 32'(rd_valid), 32'(1));
      check("t3_rd_data", 32'(rd_data), 32'h10 + 32'(i));
      cyc(0, '0, 1, 0);
    end
    check("t3_fill1", 32'(fill), 32'(1));
    check("t3_flag_hold", 32'(buf_ready), 32'(1));
    check("t3_rd_data4", 32'(rd_data), 32'h13);
    cyc(0, '0, 1, 0);
    check("t3_fill0", 32'(fill), 32'(0));
    cyc(0, '0, 0, 0);
    check("t3_flag_down", 32'(buf_ready), 32'(0));

    // 4. overflow on a full buffer
    for (int i = 0; i < 10; i++) cyc(1, 24'h100 + 24'(i), 0, 0);
    check("t4_fill8", 32'(fill), 32'(8));
    check("t4_ovf", 32'(ovf), 32'(1));
    for (int i = 0; i < 8; i++) begin
      check("t4_rd_valid", 32'(rd_valid), 32'(1));
      check("t4_rd_data", 32'(rd_data), 32'h100 + 32'(i));
      cyc(0, '0, 1, 0);
    end
    check("t4_fill_empty", 32'(fill), 32'(0));
    check("t4_ovf_sticky", 32'(ovf), 32'(1));
    cyc(0, '0, 0, 1);
    check("t4_ovf_clr", 32'(ovf), 32'(0));
    cyc(0, '0, 0, 0);

    // 5. ramp across pointer wrap with random ready
    cap_en = 1'b1;
    sent = 0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      logic wv;
      wv = (q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      cyc(wv, RAMP0 + 24'(sent), 1'($urandom_range(0, 1)), 0);
      if (wv) sent++;
    end
    check("t5_sent", 32'(sent), 32'(1000));
    drain = 0;
    while (q.size() > 0 && drain < 100) begin
      cyc(0, '0, 1, 0);
      drain++;
    end
    cyc(0, '0, 0, 0);
    cap_en = 1'b0;
    check("t5_drained_fill", 32'(fill), 32'(0));
    check("t5_rx_count", 32'(rx.size()), 32'(1000));
    for (int i = 0; i < rx.size() && i < 1000; i++)
      check("t5_ramp", 32'(rx[i]), 32'(RAMP0 + 24'(i)));
    check("t5_ovf", 32'(ovf), 32'(0));

    // 6. write+read on a full buffer, then reset mid-stream
    for (int i = 0; i < 8; i++) cyc(1, 24'h200 + 24'(i), 0, 0);
    cyc(0, '0, 0, 0);
    check("t6_full", 32'(fill), 32'(8));
    check("t6_head", 32'(rd_data), 32'h200);
    cyc(1, 24'hABCDEF, 1, 0);
    check("t6_fill7", 32'(fill), 32'(7));
    check("t6_ovf", 32'(ovf), 32'(1));
    check("t6_next_head", 32'(rd_data), 32'h201);
    cyc(0, '0, 1, 0);
    check("t6_fill6", 32'(fill), 32'(6));
    rst_n = 1'b0;
    cyc(0, '0, 1, 0);
    check("t6_rst_valid", 32'(rd_valid), 32'(0));
    check("t6_rst_fill", 32'(fill), 32'(0));
    check("t6_rst_data", 32'(rd_data), 32'(0));
    check("t6_rst_ovf", 32'(ovf), 32'(0));
    check("t6_rst_flag", 32'(buf_ready), 32'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, '0, 0, 0);
    check("t6_post_valid", 32'(rd_valid), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
